// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;
    localparam int DEF_N     = 4;
    localparam int DEF_DEPTH = 2;

    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_PARTIAL, FIFO_FULL} fifo_state_t;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/stream_demux1to2_if.sv
// Handshake bundle between producer, the demux and its two consumers.
interface stream_demux1to2_if
    import stream_demux_pkg::*;
#(
    parameter int N = DEF_N
);
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [N-1:0] in_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [N-1:0] b_data;

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/stream_fifo.sv
// Per-output FIFO; head is always mem[rd_ptr], so it keeps its last value when empty.
module stream_fifo
    import stream_demux_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [N-1:0] head,
    output fifo_state_t  state
);
    localparam int            PW       = ptr_w(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [PW:0]               count_q, count_d;
    logic [DEPTH-1:0][N-1:0]   mem_q;
    logic                      do_push, do_pop;

    always_comb begin
        state = FIFO_PARTIAL;
        if (count_q == '0)           state = FIFO_EMPTY;
        else if (count_q == FULL_CNT) state = FIFO_FULL;
    end

    assign full    = (state == FIFO_FULL);
    assign empty   = (state == FIFO_EMPTY);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Memory is reset too so head reads zero after reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/stream_demux1to2.sv
// 1-to-2 stream demux: in_sel=1 routes to port a, 0 to port b, each through its own FIFO.
// Optional per-port beat counters when STREAM_DEMUX_CNT_EN is defined.
module stream_demux1to2
    import stream_demux_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_demux1to2_if.slave  bus
`ifdef STREAM_DEMUX_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [15:0]        a_count,
    output logic [15:0]        b_count
`endif
);
    logic        a_full, a_empty, b_full, b_empty;
    logic        push_a, push_b, pop_a, pop_b, accept;
    fifo_state_t a_state, b_state;

    // Readiness looks only at registered fill state and in_sel, never at the consumers.
    assign bus.in_ready = rst_n && !(bus.in_sel ? a_full : b_full);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push_a       = accept && bus.in_sel;
    assign push_b       = accept && !bus.in_sel;
    assign pop_a        = bus.a_ready && !a_empty;
    assign pop_b        = bus.b_ready && !b_empty;
    assign bus.a_valid  = (a_state != FIFO_EMPTY);
    assign bus.b_valid  = (b_state != FIFO_EMPTY);

    stream_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .din(bus.in_data),
        .full(a_full), .empty(a_empty), .head(bus.a_data), .state(a_state)
    );

    stream_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .din(bus.in_data),
        .full(b_full), .empty(b_empty), .head(bus.b_data), .state(b_state)
    );

`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (cnt_clr) begin
            a_cnt_d = '0;
            b_cnt_d = '0;
        end else begin
            if (push_a && a_cnt_q != 16'hFFFF) a_cnt_d = a_cnt_q + 16'd1;
            if (push_b && b_cnt_q != 16'hFFFF) b_cnt_d = b_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;
`endif
endmodule

// File: tb/tb_stream_demux1to2.sv
// Bench for stream_demux1to2: directed scenarios plus a random soak against queue models.
module tb_stream_demux1to2;
    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   errs    = 0;

    stream_demux1to2_if #(.N(N)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] a_count, b_count;
`endif

    stream_demux1to2 #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .a_count(a_count),
        .b_count(b_count)
`endif
    );

    always #5 clk = ~clk;

    // Producer rule: a stalled beat must keep its select and payload.
    logic       hold_pend = 1'b0;
    logic       hold_sel;
    logic [N-1:0] hold_data;
    always @(posedge clk) begin
        if (rst_n && hold_pend) begin
            vectors++;
            if (!(bus.in_valid && bus.in_sel === hold_sel && bus.in_data === hold_data)) begin
                errs++;
                $display("FAIL hold_stable: got v=%b sel=%b d=%h want v=1 sel=%b d=%h",
                         bus.in_valid, bus.in_sel, bus.in_data, hold_sel, hold_data);
            end
        end
        hold_pend = rst_n && bus.in_valid && !bus.in_ready;
        hold_sel  = bus.in_sel;
        hold_data = bus.in_data;
    end

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({bus.in_ready, bus.a_valid, bus.b_valid} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags: got rdy/av/bv=%b want 000", {bus.in_ready, bus.a_valid, bus.b_valid});
        end
        vectors++;
        if (bus.a_data !== 4'h0 || bus.b_data !== 4'h0) begin
            errs++;
            $display("FAIL reset_data: got a=%h b=%h want 0 0", bus.a_data, bus.b_data);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.a_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: got rdy=%b av=%b want 1 0", bus.in_ready, bus.a_valid);
        end
`ifdef STREAM_DEMUX_CNT_EN
        vectors++;
        if (a_count !== 16'd0 || b_count !== 16'd0) begin
            errs++;
            $display("FAIL reset_counts: got a=%0d b=%0d want 0 0", a_count, b_count);
        end
`endif
    endtask

`ifdef STREAM_DEMUX_CNT_EN
    task automatic test_counters();
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sel   = (i < 3);
            bus.in_data  = 4'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (a_count !== 16'd3 || b_count !== 16'd5) begin
            errs++;
            $display("FAIL cnt_before_clr: got a=%0d b=%0d want 3 5", a_count, b_count);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        cnt_clr      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt_clr      = 1'b0;
        #1;
        vectors++;
        if (a_count !== 16'd0 || b_count !== 16'd0) begin
            errs++;
            $display("FAIL cnt_after_clr: got a=%0d b=%0d want 0 0", a_count, b_count);
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_basic_routing();
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 4'hA;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL route_rdy: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_sel = 1'b0; bus.in_data = 4'h5;
        #1;
        vectors++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 4'hA || bus.b_valid !== 1'b0) begin
            errs++; $display("FAIL route_a: got av=%b ad=%h bv=%b want 1 a 0", bus.a_valid, bus.a_data, bus.b_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b1 || bus.b_data !== 4'h5) begin
            errs++; $display("FAIL route_b: got av=%b bv=%b bd=%h want 0 1 5", bus.a_valid, bus.b_valid, bus.b_data);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.b_valid !== 1'b0) begin
            errs++; $display("FAIL route_b_once: got bv=%b want 0", bus.b_valid);
        end
    endtask

    task automatic test_full_isolation();
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 4'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sel = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            errs++; $display("FAIL full_a_rdy: got %b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 4'h3;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL iso_b_rdy: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus.b_valid !== 1'b1 || bus.b_data !== 4'h3 || bus.a_valid !== 1'b1 || bus.a_data !== 4'h1) begin
            errs++; $display("FAIL iso_heads: got bv=%b bd=%h av=%b ad=%h want 1 3 1 1",
                             bus.b_valid, bus.b_data, bus.a_valid, bus.a_data);
        end
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 4'h2 || bus.b_valid !== 1'b0) begin
            errs++; $display("FAIL iso_drain: got av=%b ad=%h bv=%b want 1 2 0", bus.a_valid, bus.a_data, bus.b_valid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        bus.a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 4'(i);
            #1;
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                errs++; $display("FAIL wrap_rdy[%0d]: got %b want 1", i, bus.in_ready);
            end
            if (i > 0) begin
                vectors++;
                if (bus.a_valid !== 1'b1 || bus.a_data !== 4'(i - 1)) begin
                    errs++; $display("FAIL wrap_data[%0d]: got av=%b ad=%h want 1 %h", i, bus.a_valid, bus.a_data, 4'(i - 1));
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 4'hF || bus.b_valid !== 1'b0) begin
            errs++; $display("FAIL wrap_last: got av=%b ad=%h bv=%b want 1 f 0", bus.a_valid, bus.a_data, bus.b_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.a_valid !== 1'b0) begin
            errs++; $display("FAIL wrap_empty: got av=%b want 0", bus.a_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.a_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 4'(9 + i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sel = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.a_valid, bus.b_valid} !== 3'b000) begin
            errs++; $display("FAIL midrst_async: got rdy/av/bv=%b want 000", {bus.in_ready, bus.a_valid, bus.b_valid});
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.a_data !== 4'h0 || bus.b_data !== 4'h0) begin
            errs++; $display("FAIL midrst_after: got av=%b bv=%b ad=%h bd=%h want 0 0 0 0",
                             bus.a_valid, bus.b_valid, bus.a_data, bus.b_data);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL midrst_rdy: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_random_soak();
        logic [N-1:0] qa[$];
        logic [N-1:0] qb[$];
        bit pend = 0;
        bit exp_rdy, acc, popa, popb;
        do_reset();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (!pend) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 1'($urandom_range(0, 1));
                bus.in_data  = N'($urandom);
            end
            bus.a_ready = ($urandom_range(0, 2) != 0);
            bus.b_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = bus.in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
            vectors++;
            if (bus.in_ready !== exp_rdy) begin
                errs++; $display("FAIL soak_rdy@%0d: got %b want %b", cyc, bus.in_ready, exp_rdy);
            end
            vectors++;
            if (bus.a_valid !== (qa.size() != 0) || bus.b_valid !== (qb.size() != 0)) begin
                errs++; $display("FAIL soak_valid@%0d: got av=%b bv=%b want %b %b",
                                 cyc, bus.a_valid, bus.b_valid, qa.size() != 0, qb.size() != 0);
            end
            if (qa.size() != 0) begin
                vectors++;
                if (bus.a_data !== qa[0]) begin
                    errs++; $display("FAIL soak_adata@%0d: got %h want %h", cyc, bus.a_data, qa[0]);
                end
            end
            if (qb.size() != 0) begin
                vectors++;
                if (bus.b_data !== qb[0]) begin
                    errs++; $display("FAIL soak_bdata@%0d: got %h want %h", cyc, bus.b_data, qb[0]);
                end
            end
            acc  = bus.in_valid && exp_rdy;
            popa = (qa.size() != 0) && bus.a_ready;
            popb = (qb.size() != 0) && bus.b_ready;
            pend = bus.in_valid && !exp_rdy;
            @(posedge clk);
            if (popa) void'(qa.pop_front());
            if (popb) void'(qb.pop_front());
            if (acc) begin
                if (bus.in_sel) qa.push_back(bus.in_data);
                else            qb.push_back(bus.in_data);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
`ifdef STREAM_DEMUX_CNT_EN
        test_counters();
`endif
        test_basic_routing();
        test_full_isolation();
        test_wrap();
        test_reset_mid();
        test_random_soak();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
